// File: rtl/id_exe_pkg.sv
// id_exe_pkg: shared state encoding, default widths and control-field bit positions for the ID/EXE skid register
package id_exe_pkg;
  typedef enum logic [1:0] {ST_EMPTY = 2'd0, ST_ONE = 2'd1, ST_TWO = 2'd2} state_e;
  localparam int CTRL_W_DEF   = 9;
  localparam int DATA_W_DEF   = 105;
  localparam int WB_EN_BIT    = 8;
  localparam int MEM_R_EN_BIT = 7;
  localparam int MEM_W_EN_BIT = 6;
  localparam int B_BIT        = 5;
  localparam int S_BIT        = 4;
  localparam int EXE_CMD_MSB  = 3;
  localparam int EXE_CMD_LSB  = 0;
endpackage

// File: rtl/pipe_reg_en.sv
// pipe_reg_en: enabled register with async active-low reset and sync clear (clear wins over load)
module pipe_reg_en #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q_o <= '0;
    else if (clr_i) q_o <= '0;
    else if (en_i) q_o <= d_i;
endmodule

// File: rtl/id_exe_skid_reg.sv
// id_exe_skid_reg: two-entry valid/ready skid buffer between ID and EXE; in_ready depends on state only
module id_exe_skid_reg
  import id_exe_pkg::*;
#(
  parameter int CTRL_W     = CTRL_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter bit CLEAR_DATA = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);
  localparam int W = CTRL_W + DATA_W;
  state_e state_q, state_d;
  logic [W-1:0] main_q, main_d, skid_q;
  logic in_fire, out_fire, main_en, skid_en, clr;
  assign in_ready  = state_q != ST_TWO;
  assign out_valid = state_q != ST_EMPTY;
  assign occupancy = state_q;
  assign out_ctrl  = out_valid ? main_q[W-1 -: CTRL_W] : '0;
  assign out_data  = main_q[DATA_W-1:0];
  always_comb begin
    in_fire  = in_valid & in_ready & ~flush;
    out_fire = out_valid & out_ready;
    main_en  = ~flush & ((state_q == ST_EMPTY & in_fire) | (state_q == ST_ONE & in_fire & out_fire) |
                         (state_q == ST_TWO & out_fire));
    skid_en  = state_q == ST_ONE & in_fire & ~out_fire;
    main_d   = state_q == ST_TWO ? skid_q : {in_ctrl, in_data};
    clr      = flush & CLEAR_DATA;
    // occupancy arithmetic; in_ready blocks a push in TWO and out_valid blocks a pop in EMPTY
    state_d  = flush ? ST_EMPTY : state_e'(state_q + {1'b0, in_fire} - {1'b0, out_fire});
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state_q <= ST_EMPTY;
    else state_q <= state_d;
  pipe_reg_en #(.W(W)) u_main (
    .clk(clk), .rst_n(rst), .en_i(main_en), .clr_i(clr), .d_i(main_d), .q_o(main_q)
  );
  pipe_reg_en #(.W(W)) u_skid (
    .clk(clk), .rst_n(rst), .en_i(skid_en), .clr_i(clr), .d_i({in_ctrl, in_data}), .q_o(skid_q)
  );
endmodule
